// File: rtl/tt_penguronik_sum_accum.sv
`default_nettype none
// ============================================================================
// Module      : tt_penguronik_sum_accum
// Description : Accumulates FRAME_LEN 8-bit sums into a 16-bit total and
//               streams it out as two bytes (high byte first) over valid/ready.
//               Optional saturation is enabled by defining SUM_ACC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_penguronik_sum_accum #(
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_cnt,
    output logic       ovf
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_EMIT_HI = 2'd1,
        ST_EMIT_LO = 2'd2
    } state_t;

    localparam logic [CNT_W:0] c_frame_len = (CNT_W + 1)'(FRAME_LEN);

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_acc;
    logic [15:0]      r_hold;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_frame_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic [7:0]       w_addend;
    logic [CNT_W:0]   w_cnt_inc;
    logic [15:0]      w_acc_next;
    logic             w_close;

    assign w_in_ready = rst_n && (r_state == ST_ACCUM);
    assign w_accept   = in_valid && w_in_ready;
    assign w_addend   = w_accept ? in_data : 8'd0;
    assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

`ifdef SUM_ACC_SATURATE_EN
    logic [16:0] w_sum17;
    logic        r_ovf;

    assign w_sum17    = {1'b0, r_acc} + {9'd0, w_addend};
    assign w_acc_next = w_sum17[16] ? 16'hFFFF : w_sum17[15:0];

    // Sticky until reset; the clamp itself keeps later adds pinned at 0xFFFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept && w_sum17[16]) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_acc_next = r_acc + {8'd0, w_addend};
    assign ovf        = 1'b0;
`endif

    // A frame closes on its last sample or on a flush that has data to emit
    // (either already accumulated or arriving in the flush cycle itself).
    assign w_close = (r_state == ST_ACCUM) &&
                     ((w_accept && (w_cnt_inc == c_frame_len)) ||
                      (flush && ((r_cnt != '0) || w_accept)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:   if (w_close)   w_state_next = ST_EMIT_HI;
            ST_EMIT_HI: if (out_ready) w_state_next = ST_EMIT_LO;
            ST_EMIT_LO: if (out_ready) w_state_next = ST_ACCUM;
            default:                   w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= 16'd0;
            r_hold      <= 16'd0;
            r_cnt       <= '0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_close) begin
                r_hold <= w_acc_next;
                r_acc  <= 16'd0;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
            if ((r_state == ST_EMIT_LO) && out_ready) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is asserted.
    always_comb begin
        out_data = 8'd0;
        if (rst_n) begin
            case (r_state)
                ST_EMIT_HI: out_data = r_hold[15:8];
                ST_EMIT_LO: out_data = r_hold[7:0];
                default:    out_data = 8'd0;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = rst_n && ((r_state == ST_EMIT_HI) || (r_state == ST_EMIT_LO));
    assign out_last  = rst_n && (r_state == ST_EMIT_LO);
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tt_penguronik_sum_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_penguronik_sum_accum
// Description : Directed scoreboard bench for tt_penguronik_sum_accum
//               (FRAME_LEN=4 instance plus a FRAME_LEN=300 wrap/saturate one).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_penguronik_sum_accum;

    localparam int c_flen = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_cnt;
    logic       ovf;

    logic [7:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic       b_flush;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic       b_out_last;
    logic [7:0] b_frame_cnt;
    logic       b_ovf;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] sb[$];
    int         m_acc   = 0;
    int         m_cnt   = 0;

    always #5 clk = ~clk;

    tt_penguronik_sum_accum #(.FRAME_LEN(c_flen), .CNT_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_cnt(frame_cnt), .ovf(ovf)
    );

    tt_penguronik_sum_accum #(.FRAME_LEN(300), .CNT_W(10)) u_big (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
        .frame_cnt(b_frame_cnt), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every byte transferred must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_out: observed 0x%0h expected none", {out_last, out_data});
            end else begin
                check("out_byte", {23'd0, out_last, out_data}, {23'd0, sb.pop_front()});
            end
        end
    end

    task automatic push_frame();
        sb.push_back({1'b0, 8'(m_acc >> 8)});
        sb.push_back({1'b1, 8'(m_acc)});
        m_acc = 0;
        m_cnt = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic fl);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        flush    = fl;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        m_acc    = (m_acc + int'(d)) % 65536;
        m_cnt++;
        if (m_cnt == c_flen || fl) push_frame();
    endtask

    // Counts cycles with in_ready low; also waits for the emission to finish.
    task automatic ready_gap(input int exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("in_ready_gap", n, exp);
        check("sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int unsigned tot;
        logic [15:0] b_exp;
        logic        b_ovf_exp;

        rst_n = 1'b0; in_data = 8'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        b_in_data = 8'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic frame: 10+20+30+40 = 0x0064
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
        ready_gap(2);
        check("frame_cnt_1", {24'd0, frame_cnt}, 32'd1);

        // Backpressure: 4*200 = 0x0320, high byte held for 5 cycles
        out_ready = 1'b0;
        repeat (4) send(8'd200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {24'd0, out_data}, 32'h03);
            check("hold_last", {31'd0, out_last}, 32'd0);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        ready_gap(2);
        check("frame_cnt_2", {24'd0, frame_cnt}, 32'd2);

        // Flush together with an accepted sample: 7+7+9 = 0x0017
        send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd9, 1'b1);
        ready_gap(2);
        check("frame_cnt_3", {24'd0, frame_cnt}, 32'd3);
        // Count restarted: a full frame needs exactly 4 more samples
        repeat (4) send(8'd1, 1'b0);
        ready_gap(2);
        check("frame_cnt_4", {24'd0, frame_cnt}, 32'd4);

        // Lone flush with nothing accumulated is ignored
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lone_flush_valid", {31'd0, out_valid}, 32'd0);
            check("lone_flush_ready", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk); #1;

        // Flush and junk input during EMIT_HI are ignored: 4*5 = 0x0014
        out_ready = 1'b0;
        repeat (4) send(8'd5, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("emit_flush_valid", {31'd0, out_valid}, 32'd1);
        check("emit_flush_data", {24'd0, out_data}, 32'h00);
        check("emit_flush_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ready_gap(2);
        check("frame_cnt_5", {24'd0, frame_cnt}, 32'd5);

        // Reset during EMIT_LO discards the pending low byte
        out_ready = 1'b0;
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("lo_last", {31'd0, out_last}, 32'd1);
        check("lo_data", {24'd0, out_data}, 32'h0A);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_lo_valid", {31'd0, out_valid}, 32'd0);
        check("rst_lo_data", {24'd0, out_data}, 32'd0);
        check("rst_lo_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk); #1;
        check("rst_lo_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_lo_valid2", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) send(8'd1, 1'b0);
        ready_gap(2);
        check("frame_cnt_after_rst", {24'd0, frame_cnt}, 32'd1);
        check("ovf_small", {31'd0, ovf}, 32'd0);

        // Large frame: 300 * 255 wraps (or saturates) the 16-bit total
        tot = 0;
        for (int i = 0; i < 300; i++) tot += 255;
`ifdef SUM_ACC_SATURATE_EN
        b_exp     = (tot > 32'hFFFF) ? 16'hFFFF : tot[15:0];
        b_ovf_exp = (tot > 32'hFFFF);
`else
        b_exp     = tot[15:0];
        b_ovf_exp = 1'b0;
`endif
        b_in_data  = 8'd255;
        b_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("big_latency", n, 300);
        check("big_hi", {23'd0, b_out_last, b_out_data}, {23'd0, 1'b0, b_exp[15:8]});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("big_lo", {23'd0, b_out_last, b_out_data}, {23'd0, 1'b1, b_exp[7:0]});
        @(posedge clk); #1;
        @(negedge clk);
        check("big_frame_cnt", {24'd0, b_frame_cnt}, 32'd1);
        check("big_ovf", {31'd0, b_ovf}, {31'd0, b_ovf_exp});
        check("big_idle", {31'd0, b_out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
